// File: rtl/tdc_pkg.sv
// Shared definitions for the delay-line TDC fine path.
//
// Contents:
//   TAPS_DEFAULT  default delay-line length; this is also the encoder input width
//   CODE_W        width of the binary code produced by the downstream encoder
//   ST_*          2-bit encodings of the capture FSM states
//   maj3          three-input majority vote, used by the bubble filter
package tdc_pkg;

  localparam int TAPS_DEFAULT = 16;
  localparam int CODE_W       = $clog2(TAPS_DEFAULT);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_HOLDOFF = 2'd3;

  // A tap survives the filter when at least two of the three bits
  // (itself and its two neighbours) are set.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/tdc_bubble_filter.sv
// Registered single-tap bubble filter for a delay-line thermometer word.
//
// Each output bit is the majority of the tap and its two neighbours. The
// line start reuses tap 0 as its own lower neighbour, so f[0] simply
// follows s[0]. The line end treats the tap past the last one as 0.
//
// Ports:
//   clk  in   1     system clock
//   rst  in   1     synchronous active-high reset, clears f
//   s    in   TAPS  synchronised taps, bit 0 = first tap
//   f    out  TAPS  filtered taps, one cycle after s
module tdc_bubble_filter
  import tdc_pkg::*;
#(
  parameter int TAPS = TAPS_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [TAPS-1:0] s,
  output logic [TAPS-1:0] f
);

  // Bit j of ext is tap j-1. The extra bits carry the boundary values,
  // so every majority vote reads three adjacent ext bits.
  logic [TAPS+1:0] ext;
  logic [TAPS-1:0] f_next;

  assign ext = {1'b0, s, s[0]};

  // Majority vote over each tap and its two neighbours.
  always_comb begin
    f_next = {TAPS{1'b0}};
    for (int i = 0; i < TAPS; i++) begin
      f_next[i] = maj3(ext[i], ext[i+1], ext[i+2]);
    end
  end

  // Register the filtered word.
  always_ff @(posedge clk) begin
    if (rst) begin
      f <= {TAPS{1'b0}};
    end else begin
      f <= f_next;
    end
  end

endmodule

// File: rtl/tdc_tap_capture.sv
// Tap capture front end of the delay-line TDC fine path.
//
// The block resynchronises the raw asynchronous taps and removes single-tap
// bubbles. While armed, it catches the first filtered word whose first tap
// is set. It presents that word on ip with a one-cycle en strobe for the
// downstream priority encoder. A capture is only taken when f[0] is set, so
// en never appears with ip == 0. After each capture a dead time of HOLDOFF
// cycles follows. Any hit seen during that time only raises the sticky
// missed flag.
//
// Ports:
//   clk        in   1     system clock
//   rst        in   1     synchronous active-high reset, wins over all inputs
//   arm        in   1     level; hits are accepted only while high
//   taps       in   TAPS  raw delay-line taps, bit 0 = first tap
//   ip         out  TAPS  captured thermometer word; changes only on capture
//   en         out  1     one-cycle strobe, ip valid for encoding
//   busy       out  1     high in CAPTURE or HOLDOFF
//   sat        out  1     pulse with en when ip is all ones
//   missed     out  1     sticky: hit during HOLDOFF; cleared on arm rising edge
//   hit_count  out  16    captures since reset, saturating at 16'hFFFF
module tdc_tap_capture
  import tdc_pkg::*;
#(
  parameter int          TAPS           = TAPS_DEFAULT,
  parameter int          SYNC_STAGES    = 2,
  parameter int          HOLDOFF        = 4,
  // Reset value of hit_count. It is left at zero in normal use. A nonzero
  // value lets the saturation behaviour be reached without 65535 captures.
  parameter logic [15:0] HIT_COUNT_INIT = 16'h0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            arm,
  input  logic [TAPS-1:0] taps,
  output logic [TAPS-1:0] ip,
  output logic            en,
  output logic            busy,
  output logic            sat,
  output logic            missed,
  output logic [15:0]     hit_count
);

  localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF - 1);

  logic [TAPS-1:0]   sync_ff [SYNC_STAGES];
  logic [TAPS-1:0]   filt;
  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [HOLD_W-1:0] hold_cnt;
  logic              arm_d;
  logic              hit;
  logic              capture;
  logic              missed_set;
  logic              arm_rise;
  logic              all_ones;

  // Resynchronise the raw taps. Only the last stage feeds the filter.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_ff[i] <= {TAPS{1'b0}};
      end
    end else begin
      sync_ff[0] <= taps;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_ff[i] <= sync_ff[i-1];
      end
    end
  end

  tdc_bubble_filter #(
    .TAPS (TAPS)
  ) u_filter (
    .clk (clk),
    .rst (rst),
    .s   (sync_ff[SYNC_STAGES-1]),
    .f   (filt)
  );

  // A hit means the edge has entered the line. An all-zero word can never
  // qualify, because its first tap is clear.
  assign hit      = filt[0];
  assign all_ones = &filt;
  assign arm_rise = arm & ~arm_d;

  // Next-state logic. When arm drops, it wins over a simultaneous hit.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (arm) begin
          state_next = ST_ARMED;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (!arm) begin
          state_next = ST_IDLE;
        end else if (hit) begin
          state_next = ST_CAPTURE;
        end else begin
          state_next = ST_ARMED;
        end
      end
      ST_CAPTURE: begin
        state_next = ST_HOLDOFF;
      end
      ST_HOLDOFF: begin
        if (hold_cnt == {HOLD_W{1'b0}}) begin
          if (arm) begin
            state_next = ST_ARMED;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          state_next = ST_HOLDOFF;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Decode the cycle's capture and missed-hit events from the current state.
  always_comb begin
    capture    = 1'b0;
    missed_set = 1'b0;
    if (state == ST_ARMED) begin
      capture = arm & hit;
    end else if (state == ST_HOLDOFF) begin
      missed_set = hit;
    end else begin
      capture    = 1'b0;
      missed_set = 1'b0;
    end
  end

  // FSM state register and dead-time counter. The counter loads while in
  // CAPTURE, so HOLDOFF lasts exactly HOLDOFF cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      hold_cnt <= {HOLD_W{1'b0}};
    end else begin
      state <= state_next;
      if (state == ST_CAPTURE) begin
        hold_cnt <= HOLD_LOAD;
      end else if ((state == ST_HOLDOFF) && (hold_cnt != {HOLD_W{1'b0}})) begin
        hold_cnt <= hold_cnt - HOLD_W'(1);
      end else begin
        hold_cnt <= hold_cnt;
      end
    end
  end

  // Registered outputs. ip only loads on a capture, so the encoder output
  // stays stable between strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      ip    <= {TAPS{1'b0}};
      en    <= 1'b0;
      sat   <= 1'b0;
      busy  <= 1'b0;
      arm_d <= 1'b0;
    end else begin
      en    <= capture;
      sat   <= capture & all_ones;
      busy  <= (state_next == ST_CAPTURE) || (state_next == ST_HOLDOFF);
      arm_d <= arm;
      if (capture) begin
        ip <= filt;
      end else begin
        ip <= ip;
      end
    end
  end

  // Sticky missed flag. If a set and an arm rising edge occur in the same
  // cycle, the set wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      missed <= 1'b0;
    end else if (missed_set) begin
      missed <= 1'b1;
    end else if (arm_rise) begin
      missed <= 1'b0;
    end else begin
      missed <= missed;
    end
  end

  // Saturating capture counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count <= HIT_COUNT_INIT;
    end else if (capture && (hit_count != 16'hFFFF)) begin
      hit_count <= hit_count + 16'h0001;
    end else begin
      hit_count <= hit_count;
    end
  end

endmodule

// File: tb/tb_tdc_tap_capture.sv
// Testbench for tdc_tap_capture. The reference model describes the block in
// terms of capture events and dead-time windows. A per-cycle compare checks
// both instances against that model. Directed sequences with literal
// expectations pin the model itself.
module tb_tdc_tap_capture;
  import tdc_pkg::*;

  localparam int TAPS = 16;
  localparam int SS   = 2;
  localparam int HO   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        arm;
  logic [15:0] taps;

  logic [15:0] ip,  ip2;
  logic        en,  en2;
  logic        busy, busy2;
  logic        sat, sat2;
  logic        missed, missed2;
  logic [15:0] hit_count, hit_count2;

  int total = 0;
  int bad   = 0;

  tdc_tap_capture #(.TAPS(TAPS), .SYNC_STAGES(SS), .HOLDOFF(HO)) dut (
    .clk(clk), .rst(rst), .arm(arm), .taps(taps), .ip(ip), .en(en),
    .busy(busy), .sat(sat), .missed(missed), .hit_count(hit_count)
  );

  tdc_tap_capture #(.TAPS(TAPS), .SYNC_STAGES(SS), .HOLDOFF(HO),
                    .HIT_COUNT_INIT(16'hFFFE)) dut_sat (
    .clk(clk), .rst(rst), .arm(arm), .taps(taps), .ip(ip2), .en(en2),
    .busy(busy2), .sat(sat2), .missed(missed2), .hit_count(hit_count2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad < 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference majority filter: taps before the line copy tap 0, past the end read 0.
  function automatic logic [15:0] model_filter(input logic [15:0] s);
    logic [15:0] r;
    int lo, mid, hi;
    r = 16'h0000;
    for (int i = 0; i < TAPS; i++) begin
      lo  = (i == 0) ? int'(s[0]) : int'(s[i-1]);
      mid = int'(s[i]);
      hi  = (i == TAPS-1) ? 0 : int'(s[i+1]);
      r[i] = ((lo + mid + hi) >= 2);
    end
    return r;
  endfunction

  // Priority encoder of the downstream stage: index of the highest set bit.
  function automatic logic [CODE_W-1:0] encode(input logic [15:0] v);
    int r = 0;
    for (int i = 0; i < TAPS; i++) if (v[i]) r = i;
    return CODE_W'(r);
  endfunction

  // ---------------- behavioural model ----------------
  logic [15:0] m_s [SS];
  logic [15:0] m_f = 16'h0000, m_ip = 16'h0000;
  logic [15:0] m_cnt = 16'h0000, m_cnt2 = 16'hFFFE;
  bit m_en, m_sat, m_missed, m_busy, m_armed, m_dead, m_arm_prev, m_valid;
  int m_edge = 0, m_cap_edge = 0;

  always @(posedge clk) begin
    logic [15:0] f_old;
    bit hit, rise, mset;
    int d;
    f_old = m_f;
    hit   = f_old[0];
    if (rst) begin
      for (int i = 0; i < SS; i++) m_s[i] = 16'h0000;
      m_f = 16'h0000; m_ip = 16'h0000; m_cnt = 16'h0000; m_cnt2 = 16'hFFFE;
      m_en = 0; m_sat = 0; m_missed = 0; m_busy = 0;
      m_armed = 0; m_dead = 0; m_arm_prev = 0;
    end else begin
      m_f = model_filter(m_s[SS-1]);
      for (int i = SS-1; i > 0; i--) m_s[i] = m_s[i-1];
      m_s[0] = taps;
      rise = arm && !m_arm_prev;
      m_arm_prev = arm;
      m_en = 0; m_sat = 0; mset = 0;
      if (m_dead) begin
        // d counts edges since the capture edge. Edge 1 is the strobe
        // cycle, and edges 2..HO+1 are the dead time.
        d = m_edge - m_cap_edge;
        if (d >= 2 && hit) mset = 1;
        if (d == HO + 1) begin
          m_dead  = 0;
          m_armed = arm;
        end
      end else if (!m_armed) begin
        m_armed = arm;
      end else if (!arm) begin
        m_armed = 0;
      end else if (hit) begin
        m_dead = 1;
        m_cap_edge = m_edge;
        m_en  = 1;
        m_ip  = f_old;
        m_sat = (f_old == 16'hFFFF);
        if (m_cnt  != 16'hFFFF) m_cnt  = m_cnt  + 16'h0001;
        if (m_cnt2 != 16'hFFFF) m_cnt2 = m_cnt2 + 16'h0001;
      end
      m_busy = m_dead;
      if (mset) m_missed = 1;
      else if (rise) m_missed = 0;
    end
    m_edge++;
    m_valid = 1;
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("ip", ip, m_ip);
      check("en", en, m_en);
      check("busy", busy, m_busy);
      check("sat", sat, m_sat);
      check("missed", missed, m_missed);
      check("hit_count", hit_count, m_cnt);
      check("ip2", ip2, m_ip);
      check("en2", en2, m_en);
      check("busy2", busy2, m_busy);
      check("sat2", sat2, m_sat);
      check("missed2", missed2, m_missed);
      check("hit_count2", hit_count2, m_cnt2);
      if (en && ip == 16'h0000) check("en_with_zero_ip", 32'd1, 32'd0);
    end
  end

  // ---------------- directed stimulus ----------------
  // Drive pat for hold cycles, then watch en for a bounded window.
  task automatic run_hit(input logic [15:0] pat, input int hold, input int window,
                         output int lat, output int pulses,
                         output logic [15:0] ip_at, output logic sat_at);
    lat = -1; pulses = 0; ip_at = 16'h0000; sat_at = 1'b0;
    @(negedge clk);
    taps = pat;
    for (int k = 1; k <= window; k++) begin
      @(negedge clk);
      if (k == hold) taps = 16'h0000;
      if (en) begin
        pulses++;
        if (lat < 0) begin
          lat = k; ip_at = ip; sat_at = sat;
        end
      end
    end
  endtask

  task automatic toggle_arm();
    @(negedge clk); arm = 1'b0;
    @(negedge clk); arm = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int lat, pulses, cnt;
    logic [15:0] ipa;
    logic sata;
    rst = 1'b1; arm = 1'b0; taps = 16'h0000;
    repeat (3) @(negedge clk);
    check("reset_ip", ip, 16'h0000);
    check("reset_en", en, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_missed", missed, 1'b0);
    check("reset_hit_count", hit_count, 16'h0000);
    rst = 1'b0;

    // 1: clean thermometer word, fixed latency
    arm = 1'b1;
    repeat (2) @(negedge clk);
    run_hit(16'h00FF, 5, 12, lat, pulses, ipa, sata);
    check("t1_latency", lat, 32'd4);
    check("t1_pulses", pulses, 32'd1);
    check("t1_ip", ipa, 16'h00FF);
    check("t1_op", encode(ipa), 4'h7);
    check("t1_hit_count", hit_count, 16'h0001);
    toggle_arm();
    check("t1_missed_cleared", missed, 1'b0);

    // 2: bubble removal, single tap, isolated tap
    run_hit(16'h00F7, 2, 12, lat, pulses, ipa, sata);
    check("t2_bubble_ip", ipa, 16'h00FF);
    run_hit(16'h0001, 2, 12, lat, pulses, ipa, sata);
    check("t2_single_ip", ipa, 16'h0001);
    run_hit(16'h0008, 2, 12, lat, pulses, ipa, sata);
    check("t2_isolated_pulses", pulses, 32'd0);
    check("t2_ip_held", ip, 16'h0001);
    check("t2_hit_count", hit_count, 16'h0003);

    // 3: saturated line, then a second hit inside the dead time
    toggle_arm();
    lat = -1; pulses = 0; sata = 1'b0; ipa = 16'h0000;
    @(negedge clk); taps = 16'hFFFF;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1 || k == 3) taps = 16'h0000;
      if (k == 2) taps = 16'hFFFF;
      if (en) begin
        pulses++;
        if (lat < 0) begin lat = k; ipa = ip; sata = sat; end
      end
    end
    check("t3_latency", lat, 32'd4);
    check("t3_pulses", pulses, 32'd1);
    check("t3_sat", sata, 1'b1);
    check("t3_ip", ipa, 16'hFFFF);
    check("t3_op", encode(ipa), 4'hF);
    check("t3_missed", missed, 1'b1);
    toggle_arm();
    check("t3_missed_cleared", missed, 1'b0);

    // 4: no edge never strobes; disarmed never strobes
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (en) cnt++;
    end
    check("t4_no_en_zero_taps", cnt, 32'd0);
    arm = 1'b0;
    repeat (2) @(negedge clk);
    run_hit(16'h00FF, 5, 12, lat, pulses, ipa, sata);
    check("t4_disarmed_pulses", pulses, 32'd0);
    check("t4_disarmed_busy", busy, 1'b0);
    check("t4_hit_count", hit_count, 16'h0004);

    // random phase: the per-cycle compare does the checking
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      arm = ($urandom_range(0, 15) != 0);
      rst = ($urandom_range(0, 499) == 0);
      case ($urandom_range(0, 5))
        0: taps = 16'h0000;
        1: taps = 16'hFFFF >> $urandom_range(0, 16);
        2: taps = (16'hFFFF >> $urandom_range(0, 15)) ^ (16'h0001 << $urandom_range(0, 15));
        3: taps = 16'($urandom);
        4: taps = taps;
        default: taps = 16'h0000;
      endcase
    end

    // 5: reset one cycle before en would rise
    @(negedge clk); rst = 1'b1; arm = 1'b0; taps = 16'h0000;
    repeat (2) @(negedge clk);
    rst = 1'b0; arm = 1'b1;
    repeat (2) @(negedge clk);
    taps = 16'h00FF;
    repeat (3) @(negedge clk);
    rst = 1'b1; taps = 16'h0000;
    @(negedge clk);
    check("t5_en", en, 1'b0);
    check("t5_ip", ip, 16'h0000);
    check("t5_busy", busy, 1'b0);
    check("t5_sat", sat, 1'b0);
    check("t5_missed", missed, 1'b0);
    check("t5_hit_count", hit_count, 16'h0000);
    check("t5_hit_count2", hit_count2, 16'hFFFE);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    run_hit(16'h00FF, 2, 12, lat, pulses, ipa, sata);
    check("t5_latency", lat, 32'd4);
    check("t5_hit_count", hit_count, 16'h0001);

    // 6: saturation of the preloaded counter
    run_hit(16'h0001, 1, 12, lat, pulses, ipa, sata);
    check("t6_first_sat", hit_count2, 16'hFFFF);
    run_hit(16'h0001, 1, 12, lat, pulses, ipa, sata);
    check("t6_pulses", pulses, 32'd1);
    check("t6_hold", hit_count2, 16'hFFFF);
    check("t6_hit_count", hit_count, 16'h0003);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
